// File: rtl/inst_fetch_buf.sv
// inst_fetch_buf: PC generator, single-outstanding instruction ROM fetch and a
// DEPTH-entry prefetch FIFO that presents {pc, inst} pairs to the ID stage.
// Optional macro INST_FETCH_BUF_BYPASS_EN: when defined, a response arriving
// into an empty FIFO is forwarded combinationally to id_* in the same cycle.
module inst_fetch_buf #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4)
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     rom_ce_o,
    output logic [ADDR_W-1:0]        rom_addr_o,
    input  logic [DATA_W-1:0]        rom_data_i,
    input  logic                     rom_ready_i,
    input  logic                     branch_flag_i,
    input  logic [ADDR_W-1:0]        branch_target_i,
    input  logic                     stall_i,
    output logic                     id_valid_o,
    output logic [ADDR_W-1:0]        id_pc_o,
    output logic [DATA_W-1:0]        id_inst_o,
    output logic [$clog2(DEPTH):0]   fifo_count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = ADDR_W + DATA_W;

    // Architectural state
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              outstanding_q, outstanding_d;
    logic              drop_q, drop_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Entry storage: {pc, inst}
    logic [ENT_W-1:0]  fifo_mem [DEPTH];
    logic [ENT_W-1:0]  head;

    // Per-cycle control terms
    logic fifo_empty;
    logic fifo_full;
    logic issue;
    logic resp;
    logic accept;
    logic push;
    logic pop;
`ifdef INST_FETCH_BUF_BYPASS_EN
    logic bypass;
`endif

    // Issue/response/push/pop decisions for this cycle
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CNT_W'(DEPTH));
        // Only one request may be in flight; the FIFO slot it will land in
        // is guaranteed free because issue is gated on !fifo_full.
        issue      = rst && !outstanding_q && !branch_flag_i && !fifo_full;
        resp       = rom_ready_i && outstanding_q;
        accept     = resp && !drop_q && !branch_flag_i;
        pop        = !fifo_empty && !stall_i && !branch_flag_i;
`ifdef INST_FETCH_BUF_BYPASS_EN
        bypass     = accept && fifo_empty;
        push       = accept && !(bypass && !stall_i);
`else
        push       = accept;
`endif
    end

    // Next-state for PC, request tracking and FIFO bookkeeping
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and no latch is inferred.
        pc_d          = pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        req_addr_d    = req_addr_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;

        if (issue) begin
            pc_d          = pc_q + PC_STEP;
            outstanding_d = 1'b1;
            req_addr_d    = pc_q;
        end

        // A response always retires the in-flight request, whether it is
        // kept, discarded by a concurrent redirect, or the stale one a
        // previous redirect marked for dropping.
        if (resp) begin
            outstanding_d = 1'b0;
            drop_d        = 1'b0;
        end else if (branch_flag_i && outstanding_q) begin
            drop_d        = 1'b1;
        end

        if (branch_flag_i) begin
            pc_d     = branch_target_i;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q          <= RESET_PC;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
            req_addr_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            req_addr_q    <= req_addr_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // FIFO entry write
    // NOTE: the storage array has no reset; outputs are masked while empty, so stale contents never escape.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {req_addr_q, rom_data_i};
        end
    end

    // Outputs: fetch request and FIFO head (zero when nothing to present)
    always_comb begin
        head         = fifo_mem[rd_ptr_q];
        rom_ce_o     = issue;
        rom_addr_o   = pc_q;
        fifo_count_o = count_q;
        id_valid_o   = !fifo_empty;
        id_pc_o      = fifo_empty ? '0 : head[ENT_W-1:DATA_W];
        id_inst_o    = fifo_empty ? '0 : head[DATA_W-1:0];
`ifdef INST_FETCH_BUF_BYPASS_EN
        if (bypass) begin
            id_valid_o = 1'b1;
            id_pc_o    = req_addr_q;
            id_inst_o  = rom_data_i;
        end
`endif
    end

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Self-checking bench for inst_fetch_buf: directed vector table, hand-written
// redirect/reset sequences, and a randomized run against a queue-based model.
// Honours INST_FETCH_BUF_BYPASS_EN when the design is built with it.
module tb_inst_fetch_buf;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;
`ifdef INST_FETCH_BUF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    rom_ce_o;
    logic [ADDR_W-1:0]       rom_addr_o;
    logic [DATA_W-1:0]       rom_data_i = '0;
    logic                    rom_ready_i = 1'b0;
    logic                    branch_flag_i = 1'b0;
    logic [ADDR_W-1:0]       branch_target_i = '0;
    logic                    stall_i = 1'b0;
    logic                    id_valid_o;
    logic [ADDR_W-1:0]       id_pc_o;
    logic [DATA_W-1:0]       id_inst_o;
    logic [$clog2(DEPTH):0]  fifo_count_o;

    always #5 clk = ~clk;

    inst_fetch_buf #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
        .RESET_PC('0), .PC_STEP(PC_STEP)
    ) dut (
        .clk(clk), .rst(rst),
        .rom_ce_o(rom_ce_o), .rom_addr_o(rom_addr_o),
        .rom_data_i(rom_data_i), .rom_ready_i(rom_ready_i),
        .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
        .stall_i(stall_i),
        .id_valid_o(id_valid_o), .id_pc_o(id_pc_o), .id_inst_o(id_inst_o),
        .fifo_count_o(fifo_count_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ROM contents: unique per address, and 0x24020005 at address 0
    function automatic logic [DATA_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
        return a ^ 32'h2402_0005;
    endfunction

    // Apply inputs just after a falling edge, then let combinational paths settle
    task automatic drive(input logic rdy, input logic [DATA_W-1:0] data, input logic stl,
                         input logic br, input logic [ADDR_W-1:0] tgt);
        rom_ready_i     = rdy;
        rom_data_i      = data;
        stall_i         = stl;
        branch_flag_i   = br;
        branch_target_i = tgt;
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Check the ID-side outputs against an expected presentation
    task automatic check_id(input string tag, input logic vld, input logic [ADDR_W-1:0] pc,
                            input logic [DATA_W-1:0] inst, input int cnt);
        check({tag, "_valid"}, 64'(id_valid_o), 64'(vld));
        check({tag, "_pc"},    64'(id_pc_o),    64'(vld ? pc : '0));
        check({tag, "_inst"},  64'(id_inst_o),  64'(vld ? inst : '0));
        check({tag, "_count"}, 64'(fifo_count_o), 64'(cnt));
    endtask

    task automatic check_ce(input string tag, input logic ce, input logic [ADDR_W-1:0] addr);
        check({tag, "_ce"}, 64'(rom_ce_o), 64'(ce));
        if (ce) check({tag, "_addr"}, 64'(rom_addr_o), 64'(addr));
    endtask

    task automatic do_reset();
        drive(1'b1, '1, 1'b0, 1'b0, '0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_ce("reset", 1'b0, '0);
        check_id("reset", 1'b0, '0, '0, 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Directed table: rom_ready held high, stall held then released
    typedef struct {
        logic              rdy;
        logic              stl;
        logic              ce;
        logic [ADDR_W-1:0] addr;
        logic              vld;
        logic [ADDR_W-1:0] pc;
        int                cnt;
    } vec_t;

    vec_t vt[16];

    // Reference model state (spec-level: PC, one in-flight request, a queue)
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] inst;
    } ent_t;

    ent_t              m_q[$];
    logic [ADDR_W-1:0] m_pc;
    logic [ADDR_W-1:0] m_req;
    bit                m_out;
    bit                m_drop;

    initial begin
        logic [ADDR_W-1:0] last_req;

        // ---------------- table-driven fill / saturate / drain ----------------
        vt[0]  = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 0};
        vt[1]  = '{1'b1, 1'b1, 1'b0, 32'h00, BYP,  32'h00, 0};
        vt[2]  = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b1, 32'h00, 1};
        vt[3]  = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00, 1};
        vt[4]  = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00, 2};
        vt[5]  = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00, 2};
        vt[6]  = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h00, 3};
        vt[7]  = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00, 3};
        vt[8]  = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00, 4};
        vt[9]  = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00, 4};
        vt[10] = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h00, 4};
        vt[11] = '{1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 32'h04, 3};
        vt[12] = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h08, 2};
        vt[13] = '{1'b1, 1'b0, 1'b1, 32'h14, 1'b1, 32'h0C, 2};
        vt[14] = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h10, 1};
        vt[15] = '{1'b1, 1'b0, 1'b1, 32'h18, 1'b1, 32'h14, 1};

        do_reset();
        last_req = '0;
        for (int i = 0; i < 16; i++) begin
            drive(vt[i].rdy, rom_fn(last_req), vt[i].stl, 1'b0, '0);
            check_ce($sformatf("vec%0d", i), vt[i].ce, vt[i].addr);
            check_id($sformatf("vec%0d", i), vt[i].vld, vt[i].pc, rom_fn(vt[i].pc), vt[i].cnt);
            if (vt[i].ce) last_req = vt[i].addr;
            tick();
        end

        // ---------------- redirect with request outstanding, 3-cycle ROM ----------------
        do_reset();
        drive(1'b0, '0, 1'b0, 1'b1, 32'h10);           // redirect straight out of reset
        check_ce("br_c0", 1'b0, '0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        check_ce("br_c1", 1'b1, 32'h10);
        tick();
        drive(1'b0, '0, 1'b0, 1'b1, 32'h100);           // redirect while 0x10 in flight
        check_ce("br_c2", 1'b0, '0);
        tick();
        drive(1'b1, rom_fn(32'h10), 1'b0, 1'b0, '0);    // stale 0x10 response arrives
        check_ce("br_c3", 1'b0, '0);
        check_id("br_c3", 1'b0, '0, '0, 0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        check_ce("br_c4", 1'b1, 32'h100);
        tick();
        for (int k = 5; k < 7; k++) begin
            drive(1'b0, '0, 1'b0, 1'b0, '0);
            check_ce($sformatf("lat_c%0d", k), 1'b0, '0);
            check_id($sformatf("lat_c%0d", k), 1'b0, '0, '0, 0);
            tick();
        end
        drive(1'b1, rom_fn(32'h100), 1'b1, 1'b0, '0);
        check_ce("br_c7", 1'b0, '0);
        check_id("br_c7", BYP, 32'h100, rom_fn(32'h100), 0);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0, '0);
        check_ce("br_c8", 1'b1, 32'h104);
        check_id("br_c8", 1'b1, 32'h100, rom_fn(32'h100), 1);
        tick();

        // ---------------- redirect with push and pop in the same cycle ----------------
        do_reset();
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, rom_fn(32'((k / 2) * 4)), 1'b1, 1'b0, '0);
            tick();
        end
        drive(1'b1, rom_fn(32'h0C), 1'b0, 1'b1, 32'h200);
        check_ce("bpp_c7", 1'b0, '0);
        check_id("bpp_c7", 1'b1, 32'h0, rom_fn(32'h0), 3);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0, '0);
        check_ce("bpp_c8", 1'b1, 32'h200);
        check_id("bpp_c8", 1'b0, '0, '0, 0);
        tick();
        drive(1'b1, rom_fn(32'h200), 1'b1, 1'b0, '0);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0, '0);
        check_id("bpp_c10", 1'b1, 32'h200, rom_fn(32'h200), 1);
        tick();

        // ---------------- reset in the middle of a request ----------------
        do_reset();
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        check_ce("rmid_c0", 1'b1, 32'h0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        rst = 1'b0;
        #1;
        check_ce("rmid_c1", 1'b0, '0);
        tick();
        rst = 1'b1;
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, '0);    // late response, nothing in flight
        check_ce("rmid_c2", 1'b1, 32'h0);
        check_id("rmid_c2", 1'b0, '0, '0, 0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        check_ce("rmid_c3", 1'b0, '0);
        check_id("rmid_c3", 1'b0, '0, '0, 0);
        tick();

`ifdef INST_FETCH_BUF_BYPASS_EN
        // ---------------- same-cycle bypass into an empty FIFO ----------------
        do_reset();
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        check_ce("byp_c0", 1'b1, 32'h0);
        tick();
        drive(1'b1, 32'h2402_0005, 1'b0, 1'b0, '0);
        check_id("byp_c1", 1'b1, 32'h0, 32'h2402_0005, 0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        check_ce("byp_c2", 1'b1, 32'h4);
        check_id("byp_c2", 1'b0, '0, '0, 0);
        tick();
`endif

        // ---------------- randomized run against the reference model ----------------
        do_reset();
        m_q.delete();
        m_pc   = '0;
        m_req  = '0;
        m_out  = 1'b0;
        m_drop = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            logic              rdy, stl, br, e_ce, resp, acc, byp, e_vld;
            logic [ADDR_W-1:0] tgt, e_pc;
            logic [DATA_W-1:0] data, e_inst;
            string             tag;

            rdy  = m_out ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 5) == 0);
            stl  = ((i / 64) % 2 == 1) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2);
            br   = ($urandom_range(0, 24) == 0);
            tgt  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : ($urandom() & 32'hFFFF_FFFC);
            data = m_out ? rom_fn(m_req) : $urandom();
            drive(rdy, data, stl, br, tgt);

            e_ce  = !m_out && !br && (m_q.size() < DEPTH);
            resp  = rdy && m_out;
            acc   = resp && !m_drop && !br;
            byp   = BYP && acc && (m_q.size() == 0);
            e_vld = (m_q.size() > 0) || byp;
            if (m_q.size() > 0) begin
                e_pc   = m_q[0].pc;
                e_inst = m_q[0].inst;
            end else begin
                e_pc   = m_req;
                e_inst = data;
            end

            tag = $sformatf("rnd%0d", i);
            check_ce(tag, e_ce, m_pc);
            check_id(tag, e_vld, e_pc, e_inst, m_q.size());

            if (br) begin
                m_q.delete();
                m_pc = tgt;
                if (resp) begin
                    m_out  = 1'b0;
                    m_drop = 1'b0;
                end else if (m_out) begin
                    m_drop = 1'b1;
                end
            end else begin
                if (m_q.size() > 0 && !stl) void'(m_q.pop_front());
                if (acc && !(byp && !stl)) m_q.push_back({m_req, data});
                if (resp) begin
                    m_out  = 1'b0;
                    m_drop = 1'b0;
                end
                if (e_ce) begin
                    m_out = 1'b1;
                    m_req = m_pc;
                    m_pc  = m_pc + PC_STEP;
                end
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch_buf.md
Name: inst_fetch_buf

Overview:
- Parametrised successor to the single-register PC / IF-ID front end of the openmips core.
- Generates fetch addresses and tolerates variable-latency instruction ROM via a ready handshake.
- Buffers returned instructions with their PCs in a DEPTH-entry prefetch FIFO.
- Presents the FIFO head to the ID stage with stall and branch-redirect (flush) support.

Parameters:
- ADDR_W, 32, PC / ROM address width.
- DATA_W, 32, instruction width.
- DEPTH, 4, prefetch FIFO entries; power of 2, >= 2.
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 4, PC increment per issued fetch.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- rom_ce_o  out  1  fetch request strobe; ROM accepts the request in the same cycle.
- rom_addr_o  out  ADDR_W  fetch address, valid when rom_ce_o=1.
- rom_data_i  in  DATA_W  instruction data, valid when rom_ready_i=1.
- rom_ready_i  in  1  response for the outstanding request.
- branch_flag_i  in  1  redirect/flush request from ID.
- branch_target_i  in  ADDR_W  redirect PC.
- stall_i  in  1  ID cannot accept this cycle.
- id_valid_o  out  1  id_pc_o / id_inst_o valid.
- id_pc_o  out  ADDR_W  PC of presented instruction.
- id_inst_o  out  DATA_W  presented instruction.
- fifo_count_o  out  log2(DEPTH)+1  occupied FIFO entries.

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC; FIFO empty; outstanding=0; drop=0.
  - rom_ce_o=0, id_valid_o=0, id_pc_o=0, id_inst_o=0, fifo_count_o=0.
- Issue: rom_ce_o=1 and rom_addr_o=pc when rst=1, outstanding=0, branch_flag_i=0 and count < DEPTH.
  - Next edge: outstanding<=1, pc<=pc+PC_STEP (wraps modulo 2^ADDR_W).
  - At most one request is outstanding; the slot is reserved, so a response can never overflow the FIFO.
- Response: rom_ready_i=1 with outstanding=1 and drop=0 pushes {address of request, rom_data_i} at the edge; outstanding<=0.
  - The earliest response is the cycle after issue.
  - A new issue is allowed in the cycle after the response.
  - rom_ready_i with outstanding=0 is ignored.
- Output: id_valid_o = FIFO non-empty; id_pc_o / id_inst_o = head entry (0 when empty).
  - Pop when id_valid_o=1 and stall_i=0.
  - Push and pop in the same cycle leave the count unchanged.
- Redirect: branch_flag_i=1 at an edge:
  - FIFO cleared; pc<=branch_target_i; no issue that cycle.
  - If a request is outstanding (and not answered that same cycle), drop<=1.
  - A response arriving with branch_flag_i=1 is discarded.
  - While drop=1, the next rom_ready_i is discarded, then drop<=0 and outstanding<=0.
  - Issue resumes once outstanding=0.
  - Redirect overrides any push/pop in the same cycle.
- Latency: rom_ready_i in cycle t with FIFO empty -> id_valid_o=1 in cycle t+1.
- Back-to-back redirects: the last one wins; drop stays set until one response is consumed.
- Reset mid-request: all state cleared; a late rom_ready_i is ignored (outstanding=0).

Optional Feature:
- Macro: INST_FETCH_BUF_BYPASS_EN.
- Defined: when the FIFO is empty and an accepted response arrives (drop=0, branch_flag_i=0), rom_data_i and its PC drive id_* combinationally with id_valid_o=1 in cycle t.
  - If stall_i=0, the entry is consumed without being written to the FIFO.
  - If stall_i=1, it is written as normal.
- Undefined: no combinational path from rom_* to id_*; the latency is as above.

Test Plan:
- Reset with rom_ready_i held 1 -> rom_ce_o=1, rom_addr_o=0 in the first cycle after release; issued addresses are 0,4,8,C...; ID sees pcs 0,4,8 in order with matching data.
- stall_i=1 held, rom_ready_i=1 every cycle after a request, DEPTH=4 -> fifo_count_o saturates at 4, rom_ce_o stays 0 until stall_i drops, no instruction lost or duplicated.
- ROM latency 3 cycles -> exactly one request outstanding; rom_ce_o is never asserted while awaiting rom_ready_i.
- branch_flag_i=1, branch_target_i=0x100 with a request to 0x10 outstanding -> FIFO empty next cycle, the 0x10 response is discarded, the next issued address is 0x100, and ID sees pc=0x100 first.
- Branch and pop/push in the same cycle, FIFO holding 3 entries -> fifo_count_o=0 next cycle, id_valid_o=0.
- Bypass build: FIFO empty, stall_i=0, rom_ready_i=1 with data 0x24020005 -> id_valid_o=1, id_inst_o=0x24020005 in the same cycle, fifo_count_o stays 0.
